status_display_decoder: RTL and testbench

//   Receiving end of the water/irrigation status encoders. Takes the 2-bit water-level

---
 rtl/status_display_decoder.sv | 71 +++++++
 tb/tb_status_display_decoder.sv | 86 ++++++++
 2 files changed

// File: rtl/status_display_decoder.sv
// status_display_decoder: debounces water/irrigation codes and drives a blinking 2-digit multiplexed 7-segment display
module status_display_decoder #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLINK_DIV     = 12500000,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] water_code,
  input  logic [1:0] irrigation_code,
  output logic [1:0] an,
  output logic [6:0] seg
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);
  logic [3:0]    r_cand, r_shown;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_scan;
  logic [BW-1:0] r_blink_cnt;
  logic          r_sel, r_phase;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;
  logic [3:0]    w_in;
  logic          w_match, w_blink;
  logic [6:0]    w_water_glyph, w_irr_glyph, w_seg_next;
  logic [1:0]    w_an_next;
  always_comb begin
    w_in = {water_code, irrigation_code};
    w_match = w_in == r_cand;
    w_water_glyph = r_shown[3:2] == 2'b00 ? 7'b1000000 :
                    r_shown[3:2] == 2'b01 ? 7'b1111001 :
                    r_shown[3:2] == 2'b10 ? 7'b0100100 : 7'b0110000;
    w_irr_glyph = r_shown[1:0] == 2'b00 ? 7'b0100011 :
                  r_shown[1:0] == 2'b01 ? 7'b0100001 :
                  r_shown[1:0] == 2'b10 ? 7'b0010010 : 7'b0000110;
    w_blink = r_phase & (r_sel ? r_shown[3:2] == 2'b00 : r_shown[1:0] == 2'b11);
    // slot cycle 0 blanks both digits so the previous glyph never ghosts onto the next anode
    w_an_next = r_scan == '0 ? 2'b11 : r_sel ? 2'b01 : 2'b10;
    w_seg_next = (r_scan == '0 || w_blink) ? 7'h7F : r_sel ? w_water_glyph : w_irr_glyph;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand      <= '0;
      r_shown     <= '0;
      r_cnt       <= '0;
      r_scan      <= '0;
      r_sel       <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_an        <= 2'b11;
      r_seg       <= 7'h7F;
    end else begin
      r_cand      <= w_in;
      r_cnt       <= !w_match ? '0 : r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1;
      r_shown     <= (w_match && r_cnt == CNT_ACCEPT) ? r_cand : r_shown;
      r_scan      <= r_scan == SCAN_LAST ? '0 : r_scan + 1'b1;
      r_sel       <= r_sel ^ (r_scan == SCAN_LAST);
      r_blink_cnt <= r_blink_cnt == BLINK_LAST ? '0 : r_blink_cnt + 1'b1;
      r_phase     <= r_phase ^ (r_blink_cnt == BLINK_LAST);
      r_an        <= w_an_next;
      r_seg       <= w_seg_next;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
endmodule

// File: tb/tb_status_display_decoder.sv
// tb_status_display_decoder: directed checks of reset, scan order, glyphs, debounce and blinking
module tb_status_display_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] water = 2'b00, irr = 2'b00;
  logic [1:0] an;
  logic [6:0] seg;
  int errors = 0, checks = 0, n = 0;
  logic seen3;
  status_display_decoder #(.SCAN_DIV(4), .BLINK_DIV(16), .STABLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .water_code(water), .irrigation_code(irr), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic run_to(input int k);
    while (n < k) tick();
  endtask
  task automatic expect_out(input string tag, input logic [1:0] ea, input logic [6:0] es);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, seg, es);
  endtask
  initial begin
    logic [1:0] an_seq [8];
    logic [6:0] seg_seq [8];
    an_seq  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    seg_seq = '{7'h7F, 7'h23, 7'h23, 7'h23, 7'h7F, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset_hold", 2'b11, 7'h7F);
    end
    rst_n = 1'b1;
    n = 0;
    expect_out("reset_release", 2'b11, 7'h7F);
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("scan_seq%0d", i), an_seq[i], seg_seq[i]);
    end
    run_to(18); expect_out("idle_o", 2'b10, 7'h23);
    run_to(22); expect_out("water0_blank", 2'b01, 7'h7F);
    run_to(38); expect_out("water0_lit", 2'b01, 7'h40);
    water = 2'b10; irr = 2'b01;
    run_to(46); expect_out("water2", 2'b01, 7'h24);
    run_to(50); expect_out("irr_d_phase1", 2'b10, 7'h21);
    run_to(54); expect_out("water2_phase1", 2'b01, 7'h24);
    water = 2'b11;
    tick();
    water = 2'b10;
    seen3 = 1'b0;
    while (n < 70) begin
      tick();
      if (seg == 7'h30) seen3 = 1'b1;
    end
    check("glitch_ignored", seen3, 1'b0);
    run_to(78); expect_out("water2_after_glitch", 2'b01, 7'h24);
    irr = 2'b11;
    run_to(82); expect_out("irr_e_blank", 2'b10, 7'h7F);
    run_to(86); expect_out("water_unaffected", 2'b01, 7'h24);
    run_to(98); expect_out("irr_e_lit", 2'b10, 7'h06);
    water = 2'b11;
    run_to(102); expect_out("water3", 2'b01, 7'h30);
    rst_n = 1'b0;
    tick();
    expect_out("midslot_reset", 2'b11, 7'h7F);
    rst_n = 1'b1;
    n = 0;
    tick(); expect_out("restart_blank", 2'b11, 7'h7F);
    tick(); expect_out("shown_cleared_a", 2'b10, 7'h23);
    tick(); expect_out("shown_cleared_b", 2'b10, 7'h23);
    tick(); expect_out("reaccept_e", 2'b10, 7'h06);
    tick(); expect_out("restart_slot_blank", 2'b11, 7'h7F);
    tick(); expect_out("reaccept_3", 2'b01, 7'h30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
